// File: rtl/inst_mem_loader.sv
// -----------------------------------------------------------------------------
// inst_mem_loader
//
// Streaming boot loader for the 16K x 32 instruction RAM. Words arriving on a
// valid/ready stream are written to consecutive RAM words starting at
// base_addr. The CPU is held in reset for the whole load. A mod-2^32 checksum
// of the accepted words is reported, together with done/error status.
//
// Optional build macro: LOADER_VERIFY_EN
//   When defined, a VERIFY pass re-reads the loaded range and compares the
//   readback sum with the load checksum. It also adds the verify_fail_addr
//   output.
//
// Ports
//   clk, reset_n         clock, asynchronous active-low reset
//   start, abort         load request (sampled in IDLE) / cancel active load
//   base_addr            first RAM word address
//   word_count           number of words to load (0..DEPTH)
//   snk_data/valid/ready stream sink from the FIFO
//   mem_*                Avalon-MM master to the RAM second slave port
//   cpu_reset_req        holds the CPU in reset while loading
//   busy, done, error    status (done is a one-cycle pulse, error is sticky)
//   checksum             sum mod 2^32 of the accepted words
//   verify_fail_addr     (LOADER_VERIFY_EN only) first address where the
//                        running readback sum diverged
// -----------------------------------------------------------------------------
module inst_mem_loader #(
    parameter int ADDR_W = 14,
    parameter int DEPTH  = 16384,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                abort,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     word_count,
    input  logic [DATA_W-1:0]   snk_data,
    input  logic                snk_valid,
    output logic                snk_ready,
    output logic [ADDR_W-1:0]   mem_address,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic [DATA_W-1:0]   mem_writedata,
    input  logic [DATA_W-1:0]   mem_readdata,
    output logic                mem_clken,
    output logic                cpu_reset_req,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [DATA_W-1:0]   checksum
`ifdef LOADER_VERIFY_EN
    ,
    output logic [ADDR_W-1:0]   verify_fail_addr
`endif
);

    localparam int                SUM_W    = ADDR_W + 2;
    localparam logic [ADDR_W:0]   ONE_CNT  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ONE_ADDR = ADDR_W'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
`ifdef LOADER_VERIFY_EN
        VERIFY = 2'd2,
`endif
        FINISH = 2'd3
    } state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   addr_reg;
    logic [ADDR_W:0]     remaining_reg;
    logic [DATA_W-1:0]   checksum_reg;
    logic                error_reg;
    logic                done_reg;
    logic                cpu_reset_req_reg;
    logic                mem_chipselect_reg;
    logic                mem_write_reg;
    logic [ADDR_W-1:0]   mem_address_reg;
    logic [DATA_W-1:0]   mem_writedata_reg;

    logic [SUM_W-1:0]    end_addr;
    logic                wc_zero;
    logic                range_bad;
    logic                accept;

`ifdef LOADER_VERIFY_EN
    logic [ADDR_W-1:0]   base_reg;
    logic [ADDR_W:0]     count_reg;
    logic [ADDR_W-1:0]   acc_idx_reg;
    logic [ADDR_W-1:0]   rd_addr_reg;
    logic [ADDR_W:0]     rd_left_reg;
    logic [ADDR_W-1:0]   bus_idx_reg;
    logic                cmp_valid_reg;
    logic                cmp_last_reg;
    logic [ADDR_W-1:0]   cmp_addr_reg;
    logic [DATA_W-1:0]   run_sum_reg;
    logic [DATA_W-1:0]   run_sum_next;
    logic [DATA_W-1:0]   prefix_q_reg;
    logic                found_reg;
    logic [ADDR_W-1:0]   verify_fail_addr_reg;
    // Running write-side checksum after each loaded word, indexed by word
    // offset. The readback pass compares against it word by word so that the
    // first diverging address can be reported, not just a final mismatch.
    logic [DATA_W-1:0]   prefix_mem [0:DEPTH-1];
`else
    logic                unused_readdata;
    assign unused_readdata = ^mem_readdata;
`endif

    // Range check is done one bit wider than the sum so a load that ends
    // exactly at DEPTH is legal while anything that would wrap is rejected.
    assign end_addr  = {2'b00, base_addr} + {1'b0, word_count};
    assign wc_zero   = (word_count == '0);
    assign range_bad = (end_addr > SUM_W'(DEPTH));

    // abort drops ready in the very cycle it is seen, so no beat is accepted
    // (and therefore no write is issued) once abort has been sampled.
    assign snk_ready = (state_reg == LOAD) && (remaining_reg != '0) && !abort;
    assign accept    = snk_valid && snk_ready;

    // ---------------------------------------------------------------- FSM
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = (wc_zero || range_bad) ? FINISH : LOAD;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_next = FINISH;
                end else if (remaining_reg == '0) begin
                    // Last write is on the bus this cycle; leave afterwards.
`ifdef LOADER_VERIFY_EN
                    state_next = VERIFY;
`else
                    state_next = FINISH;
`endif
                end
            end
`ifdef LOADER_VERIFY_EN
            VERIFY: begin
                if (abort || (cmp_valid_reg && cmp_last_reg)) begin
                    state_next = FINISH;
                end
            end
`endif
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

`ifdef LOADER_VERIFY_EN
    assign run_sum_next = run_sum_reg + mem_readdata;

    always_ff @(posedge clk) begin
        if (accept) begin
            prefix_mem[acc_idx_reg] <= checksum_reg + snk_data;
        end
        // Read lines up with mem_readdata: both arrive one cycle after the
        // read address is on the bus.
        prefix_q_reg <= prefix_mem[bus_idx_reg];
    end
`endif

    // ---------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg            <= IDLE;
            addr_reg             <= '0;
            remaining_reg        <= '0;
            checksum_reg         <= '0;
            error_reg            <= 1'b0;
            done_reg             <= 1'b0;
            cpu_reset_req_reg    <= 1'b0;
            mem_chipselect_reg   <= 1'b0;
            mem_write_reg        <= 1'b0;
            mem_address_reg      <= '0;
            mem_writedata_reg    <= '0;
`ifdef LOADER_VERIFY_EN
            base_reg             <= '0;
            count_reg            <= '0;
            acc_idx_reg          <= '0;
            rd_addr_reg          <= '0;
            rd_left_reg          <= '0;
            bus_idx_reg          <= '0;
            cmp_valid_reg        <= 1'b0;
            cmp_last_reg         <= 1'b0;
            cmp_addr_reg         <= '0;
            run_sum_reg          <= '0;
            found_reg            <= 1'b0;
            verify_fail_addr_reg <= '0;
`endif
        end else begin
            state_reg          <= state_next;
            mem_chipselect_reg <= 1'b0;
            mem_write_reg      <= 1'b0;
            done_reg           <= 1'b0;
`ifdef LOADER_VERIFY_EN
            cmp_valid_reg      <= 1'b0;
`endif
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        addr_reg          <= base_addr;
                        remaining_reg     <= word_count;
                        checksum_reg      <= '0;
                        error_reg         <= range_bad && !wc_zero;
                        cpu_reset_req_reg <= 1'b1;
`ifdef LOADER_VERIFY_EN
                        base_reg             <= base_addr;
                        count_reg            <= word_count;
                        acc_idx_reg          <= '0;
                        found_reg            <= 1'b0;
                        verify_fail_addr_reg <= '0;
`endif
                    end
                end
                LOAD: begin
                    if (abort) begin
                        error_reg <= 1'b1;
                    end else if (accept) begin
                        // Write goes out on the bus the cycle after acceptance.
                        mem_chipselect_reg <= 1'b1;
                        mem_write_reg      <= 1'b1;
                        mem_address_reg    <= addr_reg;
                        mem_writedata_reg  <= snk_data;
                        addr_reg           <= addr_reg + ONE_ADDR;
                        remaining_reg      <= remaining_reg - ONE_CNT;
                        checksum_reg       <= checksum_reg + snk_data;
`ifdef LOADER_VERIFY_EN
                        acc_idx_reg        <= acc_idx_reg + ONE_ADDR;
`endif
                    end
`ifdef LOADER_VERIFY_EN
                    if (state_next == VERIFY) begin
                        // First readback address goes out right behind the
                        // final write, so it sees the freshly written word.
                        mem_chipselect_reg <= 1'b1;
                        mem_address_reg    <= base_reg;
                        rd_addr_reg        <= base_reg + ONE_ADDR;
                        rd_left_reg        <= count_reg - ONE_CNT;
                        bus_idx_reg        <= '0;
                        run_sum_reg        <= '0;
                    end
`endif
                end
`ifdef LOADER_VERIFY_EN
                VERIFY: begin
                    if (abort) begin
                        error_reg <= 1'b1;
                    end else begin
                        if (rd_left_reg != '0) begin
                            mem_chipselect_reg <= 1'b1;
                            mem_address_reg    <= rd_addr_reg;
                            rd_addr_reg        <= rd_addr_reg + ONE_ADDR;
                            rd_left_reg        <= rd_left_reg - ONE_CNT;
                        end
                        bus_idx_reg   <= bus_idx_reg + ONE_ADDR;
                        cmp_valid_reg <= mem_chipselect_reg && !mem_write_reg;
                        cmp_addr_reg  <= mem_address_reg;
                        cmp_last_reg  <= ({1'b0, bus_idx_reg} == (count_reg - ONE_CNT));
                        if (cmp_valid_reg) begin
                            run_sum_reg <= run_sum_next;
                            if ((run_sum_next != prefix_q_reg) && !found_reg) begin
                                found_reg            <= 1'b1;
                                verify_fail_addr_reg <= cmp_addr_reg;
                            end
                            if (cmp_last_reg && (run_sum_next != checksum_reg)) begin
                                error_reg <= 1'b1;
                            end
                        end
                    end
                end
`endif
                FINISH: begin
                    done_reg          <= 1'b1;
                    cpu_reset_req_reg <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // ----------------------------------------------------------- outputs
    for (genvar gi = 0; gi < DATA_W/8; gi++) begin : g_be
        assign mem_byteenable[gi] = 1'b1;
    end

    assign mem_clken      = 1'b1;
    assign mem_address    = mem_address_reg;
    assign mem_chipselect = mem_chipselect_reg;
    assign mem_write      = mem_write_reg;
    assign mem_writedata  = mem_writedata_reg;
    assign cpu_reset_req  = cpu_reset_req_reg;
    assign busy           = (state_reg != IDLE);
    assign done           = done_reg;
    assign error          = error_reg;
    assign checksum       = checksum_reg;
`ifdef LOADER_VERIFY_EN
    assign verify_fail_addr = verify_fail_addr_reg;
`endif

endmodule

// File: tb/tb_inst_mem_loader.sv
`timescale 1ns/1ps
module tb_inst_mem_loader;

    localparam int ADDR_W = 14;
    localparam int DEPTH  = 16384;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset_n = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W:0]   word_count = '0;
    logic [DATA_W-1:0] snk_data = '0;
    logic              snk_valid = 1'b0;
    logic              snk_ready;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_chipselect;
    logic              mem_write;
    logic [3:0]        mem_byteenable;
    logic [DATA_W-1:0] mem_writedata;
    logic [DATA_W-1:0] mem_readdata;
    logic              mem_clken;
    logic              cpu_reset_req;
    logic              busy;
    logic              done;
    logic              error;
    logic [DATA_W-1:0] checksum;
`ifdef LOADER_VERIFY_EN
    logic [ADDR_W-1:0] verify_fail_addr;
`endif

    inst_mem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .base_addr(base_addr), .word_count(word_count),
        .snk_data(snk_data), .snk_valid(snk_valid), .snk_ready(snk_ready),
        .mem_address(mem_address), .mem_chipselect(mem_chipselect),
        .mem_write(mem_write), .mem_byteenable(mem_byteenable),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
        .mem_clken(mem_clken), .cpu_reset_req(cpu_reset_req), .busy(busy),
        .done(done), .error(error), .checksum(checksum)
`ifdef LOADER_VERIFY_EN
        , .verify_fail_addr(verify_fail_addr)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clk) cyc++;

    // RAM model: writes commit at the clock edge, reads return one cycle later.
    logic [DATA_W-1:0] ram [0:DEPTH-1];
    logic [DATA_W-1:0] rd_q = '0;
    bit                corrupt_en = 1'b0;
    logic [ADDR_W-1:0] corrupt_addr = '0;
    always @(posedge clk) begin
        if (mem_chipselect && mem_write) ram[mem_address] <= mem_writedata;
        if (mem_chipselect && !mem_write)
            rd_q <= (corrupt_en && mem_address == corrupt_addr) ?
                    (ram[mem_address] ^ 32'h0000_0100) : ram[mem_address];
    end
    assign mem_readdata = rd_q;

    // Bus monitor, sampled away from the active edge.
    logic [ADDR_W-1:0] wr_addr_q[$];
    logic [DATA_W-1:0] wr_data_q[$];
    int cs_count = 0;
    int done_count = 0;
    int done_cyc = 0;
    logic done_cpu_req = 1'b0;
    always @(negedge clk) begin
        if (mem_chipselect) cs_count++;
        if (mem_chipselect && mem_write) begin
            wr_addr_q.push_back(mem_address);
            wr_data_q.push_back(mem_writedata);
        end
        if (done) begin
            done_count++;
            done_cyc = cyc;
            done_cpu_req = cpu_reset_req;
        end
    end

    logic [DATA_W-1:0] stim_words[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        // snk_ready cs write be[3:0] clken cpu_req busy done error
        check({tag, ".ctl"}, 32'({snk_ready, mem_chipselect, mem_write, mem_byteenable,
                                  mem_clken, cpu_reset_req, busy, done, error}),
              32'b0001_1111_0000);
        check({tag, ".addr"}, 32'(mem_address), 32'd0);
        check({tag, ".wdata"}, mem_writedata, 32'd0);
        check({tag, ".checksum"}, checksum, 32'd0);
`ifdef LOADER_VERIFY_EN
        check({tag, ".vfa"}, 32'(verify_fail_addr), 32'd0);
`endif
    endtask

    task automatic fill_words(input int n, input bit fixed);
        stim_words.delete();
        for (int i = 0; i < n; i++)
            stim_words.push_back(fixed ? (32'(i + 1) * 32'h1111_1111) : $urandom());
    endtask

    // gap_mode: 0 back-to-back, 1 alternating valid, 2 random gaps.
    task automatic run_load(input string tag, input logic [ADDR_W-1:0] base, input int n,
                            input int gap_mode, input int abort_after,
                            input bit start_with_abort, input bit poke_start);
        int wr0, cs0, dn0, idx, beat, wait_cyc, exp_n, start_cyc;
        bit over, exp_err, aborted;
        logic [DATA_W-1:0] exp_sum;
        wr0 = wr_addr_q.size();
        cs0 = cs_count;
        dn0 = done_count;

        // Expected outcome from the load rules.
        over = (n > 0) && (int'(base) + n > DEPTH);
        if (n == 0 || over) exp_n = 0;
        else if (abort_after >= 0 && abort_after < n) exp_n = abort_after;
        else exp_n = n;
        exp_err = over || (n > 0 && exp_n < n);
`ifdef LOADER_VERIFY_EN
        if (corrupt_en && n > 0 && exp_n == n) exp_err = 1'b1;
`endif
        exp_sum = '0;
        for (int i = 0; i < exp_n; i++) exp_sum += stim_words[i];

        @(posedge clk); #1;
        start = 1'b1; base_addr = base; word_count = (ADDR_W+1)'(n);
        abort = start_with_abort; start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        check({tag, ".cpu_req_during"}, 32'(cpu_reset_req), 32'd1);
        check({tag, ".busy_during"}, 32'(busy), 32'd1);

        idx = 0; beat = 0; aborted = 1'b0;
        while (idx < n && !aborted && done_count == dn0 && beat < 400) begin
            if (idx == abort_after) begin
                abort = 1'b1; snk_valid = 1'b0; aborted = 1'b1;
                @(posedge clk); #1;
                abort = 1'b0;
            end else begin
                case (gap_mode)
                    0:       snk_valid = 1'b1;
                    1:       snk_valid = (beat % 2 == 0);
                    default: snk_valid = ($urandom_range(0, 2) != 0);
                endcase
                snk_data = snk_valid ? stim_words[idx] : $urandom();
                if (poke_start && idx == 1) begin
                    start = 1'b1; base_addr = ~base;
                end
                @(negedge clk);
                if (snk_valid && snk_ready) idx++;
                @(posedge clk); #1;
                start = 1'b0; snk_valid = 1'b0;
            end
            beat++;
        end

        wait_cyc = 0;
        while (done_count == dn0 && wait_cyc < 200) begin
            @(negedge clk);
            wait_cyc++;
        end
        check({tag, ".done_seen"}, 32'(done_count > dn0), 32'd1);
        repeat (3) @(negedge clk);

        check({tag, ".done_pulses"}, 32'(done_count - dn0), 32'd1);
        check({tag, ".n_writes"}, 32'(wr_addr_q.size() - wr0), 32'(exp_n));
        for (int i = 0; i < exp_n && (wr0 + i) < wr_addr_q.size(); i++) begin
            check($sformatf("%s.wr%0d_addr", tag, i), 32'(wr_addr_q[wr0 + i]),
                  32'((int'(base) + i) % DEPTH));
            check($sformatf("%s.wr%0d_data", tag, i), wr_data_q[wr0 + i], stim_words[i]);
        end
        check({tag, ".checksum"}, checksum, exp_sum);
        check({tag, ".error"}, 32'(error), 32'(exp_err));
        check({tag, ".busy_after"}, 32'(busy), 32'd0);
        check({tag, ".cpu_req_after"}, 32'(cpu_reset_req), 32'd0);
        check({tag, ".cpu_req_at_done"}, 32'(done_cpu_req), 32'd0);
        if (over) check({tag, ".no_cs"}, 32'(cs_count - cs0), 32'd0);
        if (n == 0) check({tag, ".done_latency"}, 32'(done_cyc - start_cyc), 32'd2);
        $display("txn %s base=0x%04h n=%0d writes=%0d checksum=0x%08h error=%0b",
                 tag, base, n, wr_addr_q.size() - wr0, checksum, error);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr_at_rst;
        logic [ADDR_W-1:0] rb;
        int rn;

        // Asynchronous reset, checked before any clock edge.
        #2 reset_n = 1'b0;
        #1 check_reset_vals("reset");
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        fill_words(4, 1'b1);
        run_load("basic", 14'h0100, 4, 0, -1, 1'b0, 1'b0);
        check("basic.sum_const", checksum, 32'hAAAA_AAAA);

        fill_words(0, 1'b0);
        run_load("zero", 14'h0040, 0, 0, -1, 1'b0, 1'b0);

        fill_words(3, 1'b0);
        run_load("overflow", 14'h3FFE, 3, 0, -1, 1'b0, 1'b0);
        fill_words(2, 1'b0);
        run_load("top_fit", 14'h3FFE, 2, 0, -1, 1'b0, 1'b0);

        fill_words(4, 1'b0);
        run_load("gaps", 14'h0800, 4, 1, -1, 1'b0, 1'b1);

        fill_words(8, 1'b0);
        run_load("abort", 14'h0900, 8, 0, 2, 1'b0, 1'b0);

        fill_words(3, 1'b0);
        run_load("start_abort", 14'h0A00, 3, 0, -1, 1'b1, 1'b0);

        for (int t = 0; t < 6; t++) begin
            rn = $urandom_range(1, 10);
            if (t % 3 == 2) rb = 14'(DEPTH - $urandom_range(1, 6));
            else rb = 14'($urandom_range(0, DEPTH - 20));
            fill_words(rn, 1'b0);
            run_load($sformatf("rand%0d", t), rb, rn, 2, -1, 1'b0, 1'b0);
        end

`ifdef LOADER_VERIFY_EN
        corrupt_en = 1'b1;
        corrupt_addr = 14'h0C02;
        fill_words(5, 1'b0);
        run_load("verify_bad", 14'h0C00, 5, 0, -1, 1'b0, 1'b0);
        check("verify_bad.fail_addr", 32'(verify_fail_addr), 32'h0C02);
        corrupt_en = 1'b0;
        fill_words(5, 1'b0);
        run_load("verify_ok", 14'h0D00, 5, 2, -1, 1'b0, 1'b0);
`endif

        // Reset in the middle of a load.
        fill_words(8, 1'b0);
        @(posedge clk); #1;
        start = 1'b1; base_addr = 14'h0200; word_count = 15'd8;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            snk_valid = 1'b1; snk_data = stim_words[i];
            @(posedge clk); #1;
        end
        #3 reset_n = 1'b0;
        wr_at_rst = wr_addr_q.size();
        #1 check_reset_vals("midreset");
        snk_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("midreset.no_writes", 32'(wr_addr_q.size() - wr_at_rst), 32'd0);
        check("midreset.busy_held", 32'(busy), 32'd0);
        $display("txn midreset writes_before_reset=%0d", wr_at_rst);
        @(posedge clk); #1 reset_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
- Streaming boot loader that fills the 16K x 32 on-chip instruction RAM from the FIFO side of the NIOS_with_FIFO system.
- Sits directly upstream of the instruction RAM. Drives the RAM's second Avalon-MM slave port (address/chipselect/write/byteenable/writedata/clken, readdata back).
- Holds the processor in reset while loading. Reports a 32-bit checksum and a done/error status.

Parameters:
- ADDR_W, 14, RAM word-address width.
- DEPTH, 16384, RAM depth in words. Loads may not exceed it.
- DATA_W, 32, word width. Byteenable width is DATA_W/8.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle load request; sampled only in IDLE
- abort  in  1  cancel an active load
- base_addr  in  ADDR_W  first RAM word address
- word_count  in  ADDR_W+1  number of words to load (0..DEPTH)
- snk_data  in  DATA_W  stream word from FIFO
- snk_valid  in  1  stream valid
- snk_ready  out  1  loader accepts snk_data
- mem_address  out  ADDR_W  RAM word address
- mem_chipselect  out  1  RAM select
- mem_write  out  1  RAM write strobe
- mem_byteenable  out  DATA_W/8  always all-ones during access
- mem_writedata  out  DATA_W  RAM write data
- mem_readdata  in  DATA_W  RAM read data; 1-cycle latency from address
- mem_clken  out  1  RAM clock enable; constant 1 out of reset
- cpu_reset_req  out  1  holds the CPU in reset during a load
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle completion pulse
- error  out  1  sticky error; cleared on the next accepted start
- checksum  out  DATA_W  sum mod 2^32 of accepted words

Behaviour:
- Reset values (reset_n low, asynchronous): state IDLE; all outputs 0 except mem_clken=1 and mem_byteenable=all-ones. Reset mid-load abandons the load immediately; no further writes are issued.
- States: IDLE, LOAD, VERIFY, FINISH.
- IDLE -> on start:
  - Latch base_addr and word_count. Clear checksum and error.
  - Set cpu_reset_req=1.
  - If word_count==0: go to FINISH.
  - If base_addr+word_count>DEPTH (no wrap-around permitted): set error, go to FINISH; no RAM access occurs.
  - Otherwise go to LOAD.
- LOAD:
  - snk_ready=1 while remaining>0.
  - A beat is accepted when snk_valid&snk_ready. The next cycle drives mem_chipselect=1, mem_write=1, mem_address=current address, mem_writedata=word.
  - Address increments after each write; checksum adds the word on acceptance.
  - Throughput is 1 word/cycle. Gaps in snk_valid produce no write.
  - After the last write, go to VERIFY (macro enabled) or FINISH.
- abort in LOAD or VERIFY: set error, drop snk_ready that cycle, go to FINISH. No partial write is issued after abort is sampled.
- start while busy: ignored.
- FINISH: done=1 for exactly one cycle; cpu_reset_req deasserts the same cycle; return to IDLE.
- Simultaneous start and abort in IDLE: start wins; abort is ignored.

Optional Feature:
- LOADER_VERIFY_EN defined:
  - VERIFY re-reads base_addr..base_addr+word_count-1 with mem_chipselect=1, mem_write=0, pipelined one address/cycle.
  - Each mem_readdata is compared one cycle after its address, against a re-accumulated checksum.
  - Readback sum != checksum sets error. done pulses after the last compare.
  - Adds an output verify_fail_addr[ADDR_W-1:0] (first mismatching address in the running sum; reset 0).
- Undefined: VERIFY state, readback logic and verify_fail_addr are absent; LOAD goes straight to FINISH.

Test Plan:
- base_addr=0x0100, word_count=4, stream 0x11111111,0x22222222,0x33333333,0x44444444 back-to-back -> writes to 0x0100..0x0103, checksum=0xAAAAAAAA, done 1 pulse, error=0, cpu_reset_req low after done.
- word_count=0 -> no mem_write, done pulses 2 cycles after start, checksum=0, error=0.
- base_addr=0x3FFE, word_count=3 -> error=1, no mem_chipselect, done pulses; base_addr=0x3FFE, word_count=2 -> writes 0x3FFE,0x3FFF, error=0.
- snk_valid toggling 1,0,1,0 over 4 words -> exactly 4 writes at consecutive addresses, no duplicates, correct checksum.
- abort asserted after 2 of 8 words -> exactly 2 writes, error=1, done pulses, busy falls; reset_n pulsed mid-load -> all outputs at reset values asynchronously.
- LOADER_VERIFY_EN: RAM model corrupts word 2 -> error=1, verify_fail_addr=base_addr+2; clean RAM model -> error=0.
